// File: rtl/crc8_frame_pkg.sv
// Shared types and helpers for the CRC-8 framed-stream checkers on the trigger link.
package crc8_frame_pkg;

  localparam int FRAME_LEN_DEF = 10;
  localparam int CRC_POS_DEF   = 7;
  localparam logic [3:0] BYTE_IDX_IDLE = 4'hF;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // One byte of MSB-first CRC-8, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_window.sv
// Combinational CRC-8 over an N-byte window; byte 0 of the packed window is the oldest.
module crc8_window
  import crc8_frame_pkg::*;
#(
  parameter int         N          = CRC_POS_DEF,
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INITIAL    = 8'hFF
) (
  input  logic [8*N-1:0] window,
  output logic [7:0]     crc
);

  always_comb begin
    crc = INITIAL;
    for (int k = 0; k < N; k++) begin
      crc = crc8_byte(crc, window[8*k +: 8], POLYNOMIAL);
    end
  end

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side frame aligner: hunts for a CRC match on a sliding window, confirms, then tracks lock.
module crc8_frame_checker
  import crc8_frame_pkg::*;
#(
  parameter int         FRAME_LEN  = FRAME_LEN_DEF,
  parameter int         CRC_POS    = CRC_POS_DEF,
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INITIAL    = 8'hFF,
  parameter int         CONFIRM_N  = 2,
  parameter int         LOSS_N     = 3,
  parameter int         ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_i,
  input  logic                 data_valid_i,
  output logic [7:0]           data_o,
  output logic                 data_valid_o,
  output logic [3:0]           byte_counter,
  output logic                 frame_ok_o,
  output logic                 crc_err_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam logic [3:0] CRC_IDX     = 4'(CRC_POS);
  localparam logic [3:0] LAST_IDX    = 4'(FRAME_LEN - 1);
  localparam logic [3:0] CONFIRM_TGT = 4'(CONFIRM_N);
  localparam logic [3:0] LOSS_TGT    = 4'(LOSS_N);

  function automatic logic [3:0] next_idx(input logic [3:0] i);
    return (i == LAST_IDX) ? 4'd0 : i + 4'd1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                 state_p0, state_n;
  logic [3:0]             idx_p0, idx_n;
  logic [3:0]             good_p0, good_n;
  logic [3:0]             bad_p0, bad_n;
  logic [3:0]             fill_p0;
  logic [7:0]             hist_p0 [CRC_POS];
  logic [8*CRC_POS-1:0]   window;
  logic [7:0]             crc_calc;
  logic                   match;
  logic                   at_crc;
  logic [3:0]             bc_n;
  logic                   ok_n;
  logic                   err_n;
  logic [ERR_CNT_W-1:0]   cnt_n;

  // Stage p0: history window, checked before the incoming byte shifts in
  always_ff @(posedge clk) begin
    if (data_valid_i) begin
      for (int i = 0; i < CRC_POS - 1; i++) begin
        hist_p0[i] <= hist_p0[i+1];
      end
      hist_p0[CRC_POS-1] <= data_i;
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < CRC_POS; i++) begin
      window[8*i +: 8] = hist_p0[i];
    end
  end

  crc8_window #(
    .N          (CRC_POS),
    .POLYNOMIAL (POLYNOMIAL),
    .INITIAL    (INITIAL)
  ) u_window (
    .window (window),
    .crc    (crc_calc)
  );

  assign match  = (fill_p0 == CRC_IDX) && (crc_calc == data_i);
  assign at_crc = (idx_p0 == CRC_IDX);

  always_comb begin
    state_n = state_p0;
    idx_n   = idx_p0;
    good_n  = good_p0;
    bad_n   = bad_p0;
    if (data_valid_i) begin
      unique case (state_p0)
        HUNT: begin
          if (match) begin
            good_n = 4'd1;
            idx_n  = next_idx(CRC_IDX);
            if (CONFIRM_TGT == 4'd1) begin
              state_n = LOCKED;
              bad_n   = 4'd0;
            end else begin
              state_n = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          idx_n = next_idx(idx_p0);
          if (at_crc) begin
            if (match) begin
              good_n = good_p0 + 4'd1;
              if (good_p0 + 4'd1 == CONFIRM_TGT) begin
                state_n = LOCKED;
                bad_n   = 4'd0;
              end
            end else begin
              state_n = HUNT;
            end
          end
        end
        LOCKED: begin
          idx_n = next_idx(idx_p0);
          if (at_crc) begin
            if (match) begin
              bad_n = 4'd0;
            end else begin
              bad_n = bad_p0 + 4'd1;
              if (bad_p0 + 4'd1 == LOSS_TGT) state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Output decode; a CONFIRM failure still reports its CRC byte at CRC_IDX
  always_comb begin
    bc_n  = byte_counter;
    ok_n  = 1'b0;
    err_n = 1'b0;
    cnt_n = err_count_o;
    if (data_valid_i) begin
      unique case (state_p0)
        HUNT: bc_n = match ? CRC_IDX : BYTE_IDX_IDLE;
        CONFIRM: begin
          bc_n = idx_p0;
          if (at_crc) begin
            ok_n  = match;
            err_n = !match;
          end
        end
        LOCKED: begin
          bc_n = idx_p0;
          if (at_crc) begin
            ok_n  = match;
            err_n = !match;
            if (!match) cnt_n = sat_inc(err_count_o);
          end
        end
        default: bc_n = BYTE_IDX_IDLE;
      endcase
    end
  end

  // Stage p1: registered control and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0     <= HUNT;
      idx_p0       <= 4'd0;
      good_p0      <= 4'd0;
      bad_p0       <= 4'd0;
      fill_p0      <= 4'd0;
      data_o       <= 8'd0;
      data_valid_o <= 1'b0;
      byte_counter <= BYTE_IDX_IDLE;
      frame_ok_o   <= 1'b0;
      crc_err_o    <= 1'b0;
      locked_o     <= 1'b0;
      err_count_o  <= '0;
    end else begin
      state_p0     <= state_n;
      idx_p0       <= idx_n;
      good_p0      <= good_n;
      bad_p0       <= bad_n;
      if (data_valid_i && (fill_p0 != CRC_IDX)) fill_p0 <= fill_p0 + 4'd1;
      if (data_valid_i) data_o <= data_i;
      data_valid_o <= data_valid_i;
      byte_counter <= bc_n;
      frame_ok_o   <= ok_n;
      crc_err_o    <= err_n;
      locked_o     <= (state_n == LOCKED);
      err_count_o  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Randomized self-checking bench for crc8_frame_checker against a queue-based frame-alignment model.
module tb_crc8_frame_checker;

  localparam int FL = 10;
  localparam int CP = 7;
  localparam int CN = 2;
  localparam int LN = 3;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_i;
  logic          data_valid_i;
  logic [7:0]    data_o;
  logic          data_valid_o;
  logic [3:0]    byte_counter;
  logic          frame_ok_o;
  logic          crc_err_o;
  logic          locked_o;
  logic [EW-1:0] err_count_o;

  always #5 clk = ~clk;

  crc8_frame_checker #(
    .FRAME_LEN (FL), .CRC_POS (CP), .POLYNOMIAL (8'h07), .INITIAL (8'hFF),
    .CONFIRM_N (CN), .LOSS_N (LN), .ERR_CNT_W (EW)
  ) dut (
    .clk (clk), .reset (reset), .data_i (data_i), .data_valid_i (data_valid_i),
    .data_o (data_o), .data_valid_o (data_valid_o), .byte_counter (byte_counter),
    .frame_ok_o (frame_ok_o), .crc_err_o (crc_err_o), .locked_o (locked_o),
    .err_count_o (err_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the last CP accepted bytes, plus an alignment mode and frame position.
  logic [7:0] m_hist[$];
  int m_mode;    // 0 searching, 1 confirming, 2 locked
  int m_pos;
  int m_good, m_bad;
  int e_bc, e_ok, e_err, e_lock, e_cnt;

  function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
    logic [7:0] r = 8'hFF;
    foreach (q[k]) begin
      r = r ^ q[k];
      for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0;
    e_bc = 15; e_ok = 0; e_err = 0; e_lock = 0; e_cnt = 0;
  endtask

  task automatic model_step(input logic [7:0] d);
    bit good_crc;
    good_crc = (m_hist.size() == CP) && (ref_crc(m_hist) == d);
    e_ok = 0; e_err = 0;
    if (m_mode == 0) begin
      e_bc = good_crc ? CP : 15;
      if (good_crc) begin
        m_good = 1;
        m_pos  = (CP + 1) % FL;
        m_mode = (CN == 1) ? 2 : 1;
        m_bad  = 0;
      end
    end else begin
      e_bc = m_pos;
      if (m_pos == CP) begin
        if (good_crc) begin
          e_ok = 1;
          if (m_mode == 1) begin
            m_good++;
            if (m_good >= CN) begin m_mode = 2; m_bad = 0; end
          end else m_bad = 0;
        end else begin
          e_err = 1;
          if (m_mode == 1) m_mode = 0;
          else begin
            if (e_cnt < (1 << EW) - 1) e_cnt++;
            m_bad++;
            if (m_bad >= LN) m_mode = 0;
          end
        end
      end
      m_pos = (m_pos + 1) % FL;
    end
    m_hist.push_back(d);
    if (m_hist.size() > CP) void'(m_hist.pop_front());
    e_lock = (m_mode == 2);
  endtask

  task automatic drive(input logic [7:0] d, input bit v);
    data_i = d;
    data_valid_i = v;
    if (v) model_step(d);
    else begin e_ok = 0; e_err = 0; end
    @(posedge clk);
    #1;
    check_val("data_valid_o", data_valid_o, v);
    check_val("frame_ok_o", frame_ok_o, e_ok);
    check_val("crc_err_o", crc_err_o, e_err);
    check_val("locked_o", locked_o, e_lock);
    check_val("byte_counter", byte_counter, e_bc);
    check_val("err_count_o", err_count_o, e_cnt);
    if (v) check_val("data_o", data_o, d);
  endtask

  bit gaps_on = 0;

  task automatic send_byte(input logic [7:0] d);
    if (gaps_on && $urandom_range(0, 5) == 0)
      repeat ($urandom_range(1, 4)) drive(8'($urandom), 1'b0);
    drive(d, 1'b1);
  endtask

  // Frame of all-zero payload; the CRC byte is 0x44 when clean, 0x45 when corrupted.
  task automatic send_zero_frame(input bit corrupt);
    for (int i = 0; i < FL; i++) begin
      if (i == CP) send_byte(corrupt ? 8'h45 : 8'h44);
      else send_byte(8'h00);
    end
  endtask

  task automatic send_rand_frame(input bit corrupt);
    logic [7:0] pl[$];
    logic [7:0] c;
    for (int i = 0; i < CP; i++) pl.push_back(8'($urandom));
    c = ref_crc(pl);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(corrupt ? (c ^ 8'(1 << $urandom_range(0, 7))) : c);
    for (int i = CP + 1; i < FL; i++) send_byte(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data_o"}, data_o, 0);
    check_val({tag, "_data_valid_o"}, data_valid_o, 0);
    check_val({tag, "_byte_counter"}, byte_counter, 4'hF);
    check_val({tag, "_frame_ok_o"}, frame_ok_o, 0);
    check_val({tag, "_crc_err_o"}, crc_err_o, 0);
    check_val({tag, "_locked_o"}, locked_o, 0);
    check_val({tag, "_err_count_o"}, err_count_o, 0);
  endtask

  // Sends zero frames and reports how many 0x44 bytes went by before locked_o rose.
  task automatic count_44_to_lock(input int frames, output int n44_at_lock);
    int n44 = 0;
    n44_at_lock = -1;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < FL; i++) begin
        send_byte((i == CP) ? 8'h44 : 8'h00);
        if (i == CP) n44++;
        if (locked_o && n44_at_lock < 0) n44_at_lock = n44;
      end
    end
  endtask

  initial begin
    int n44;
    reset = 1'b1;
    data_i = 8'h00;
    data_valid_i = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Misaligned start then aligned zero frames
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hC3);
    count_44_to_lock(4, n44);
    check_val("lock_on_second_44", n44, 2);
    check_val("err_after_align", err_count_o, 0);

    // Three consecutive CRC errors drop lock
    for (int i = 0; i < 3; i++) send_zero_frame(1'b1);
    check_val("loss_err_count", err_count_o, 3);
    check_val("loss_locked", locked_o, 0);
    for (int i = 0; i < 3; i++) send_zero_frame(1'b0);
    check_val("relock_locked", locked_o, 1);

    // Single error while locked
    send_zero_frame(1'b1);
    check_val("single_err_count", err_count_o, 4);
    check_val("single_err_locked", locked_o, 1);
    send_zero_frame(1'b0);
    check_val("single_err_recover", locked_o, 1);

    // Same traffic with random valid gaps
    gaps_on = 1;
    for (int i = 0; i < 3; i++) send_zero_frame(1'b1);
    for (int i = 0; i < 4; i++) send_zero_frame(1'b0);
    check_val("gap_err_count", err_count_o, 7);
    check_val("gap_locked", locked_o, 1);
    gaps_on = 0;

    // Reset while locked at index 4
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    check_val("midframe_index", byte_counter, 4);
    data_valid_i = 1'b0;
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    count_44_to_lock(3, n44);
    check_val("midreset_relock_44", n44, 2);

    // Random frames, random corruption, occasional slips, random gaps
    gaps_on = 1;
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 19) == 0)
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
      send_rand_frame($urandom_range(0, 6) == 0);
    end
    gaps_on = 0;
    for (int f = 0; f < 4; f++) send_rand_frame(1'b0);
    check_val("final_locked", locked_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
